// File: rtl/router_pkg.sv
// Shared constants for the router output-channel FIFO: default geometry,
// header length-field position and the location of the packet tag bit.
package router_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_AFULL_LVL  = 14;
    localparam int DEF_AEMPTY_LVL = 2;

    // Header word layout: [WIDTH-1:LEN_LSB] is the payload length.
    localparam int LEN_LSB = 2;

    // The lfd tag is stored one bit above the data byte in each entry.
    function automatic int tag_bit(input int width);
        return width;
    endfunction

endpackage

// File: rtl/router_pkt_fifo_mem.sv
// Simple dual-port register array: one write port and one registered read port.
// The storage itself is not reset; only the read register is cleared.
module router_pkt_fifo_mem #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Write port: storage contents survive reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: the register holds its value between reads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_data <= '0;
        end else if (i_clr) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware FIFO for a router output channel. Tracks fill level with its
// own counter, exposes watermark and sticky error flags, and counts bytes of
// each packet on the read side so the parity byte raises pkt_done.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AFULL_LVL  = DEF_AFULL_LVL,
    parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   soft_reset,
    input  logic                   write_enb,
    input  logic                   read_enb,
    input  logic                   lfd_state,
    input  logic [WIDTH-1:0]       datain,
    output logic [WIDTH-1:0]       dataout,
    output logic                   data_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   pkt_done
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int PKT_W  = WIDTH - 1;
    localparam int LEN_W  = WIDTH - LEN_LSB;
    localparam int TAG    = tag_bit(WIDTH);

    localparam logic [CNT_W-1:0] FILL_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FILL_AFULL  = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] FILL_AEMPTY = CNT_W'(AEMPTY_LVL);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_fill;
    logic              r_dv;
    logic              r_ovf;
    logic              r_unf;
    logic [PKT_W-1:0]  r_pkt_cnt;

    logic              w_do_wr;
    logic              w_do_rd;
    logic [WIDTH:0]    w_rd_word;
    logic              w_rd_tag;
    logic [LEN_W-1:0]  w_len;

    // A read frees a slot in the same cycle, so a write at full is still
    // accepted when paired with a read. Reads never fall through from empty.
    assign w_do_wr = write_enb && (!full || read_enb) && !soft_reset;
    assign w_do_rd = read_enb && !empty && !soft_reset;

    router_pkt_fifo_mem #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk      (clk),
        .resetn   (resetn),
        .i_clr    (soft_reset),
        .i_wr_en  (w_do_wr),
        .i_wr_addr(r_wr_ptr),
        .i_wr_data({lfd_state, datain}),
        .i_rd_en  (w_do_rd),
        .i_rd_addr(r_rd_ptr),
        .o_rd_data(w_rd_word)
    );

    // Pointers, fill count, read-valid strobe and sticky error flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_dv     <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (soft_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_dv     <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
            r_dv <= w_do_rd;
            if (write_enb && full && !read_enb) begin
                r_ovf <= 1'b1;
            end
            if (read_enb && empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign w_rd_tag = w_rd_word[TAG];
    assign w_len    = w_rd_word[WIDTH-1:LEN_LSB];

    // Packet byte counter, advanced by each word as it appears on dataout.
    // A header (re)loads length+1 so the parity byte is the final count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pkt_cnt <= '0;
        end else if (soft_reset) begin
            r_pkt_cnt <= '0;
        end else if (r_dv) begin
            if (w_rd_tag) begin
                r_pkt_cnt <= PKT_W'(w_len) + 1'b1;
            end else if (r_pkt_cnt != '0) begin
                r_pkt_cnt <= r_pkt_cnt - 1'b1;
            end
        end
    end

    assign dataout      = w_rd_word[WIDTH-1:0];
    assign data_valid   = r_dv;
    assign fill_level   = r_fill;
    assign full         = (r_fill == FILL_FULL);
    assign empty        = (r_fill == '0);
    assign almost_full  = (r_fill >= FILL_AFULL);
    assign almost_empty = (r_fill <= FILL_AEMPTY);
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
    assign pkt_done     = r_dv && !w_rd_tag && (r_pkt_cnt == PKT_W'(1));

endmodule
